// File: rtl/nebula_axi_merge.sv
// 2:1 AXI4 read arbiter with a registered AR slot and D-side write pass-through.
// Define NEBULA_AXI_MERGE_FIXED_PRIO_EN to replace round-robin with fixed D-over-I priority.
module nebula_axi_merge #(
   parameter int PADDR_WIDTH     = 56,
   parameter int AXI_ID_WIDTH    = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [AXI_ID_WIDTH-1:0] s_i_arid,
   input  logic [PADDR_WIDTH-1:0]  s_i_araddr,
   input  logic [7:0]              s_i_arlen,
   input  logic [2:0]              s_i_arsize,
   input  logic [1:0]              s_i_arburst,
   input  logic                    s_i_arvalid,
   output logic                    s_i_arready,
   output logic [511:0]            s_i_rdata,
   output logic [1:0]              s_i_rresp,
   output logic                    s_i_rlast,
   output logic                    s_i_rvalid,
   input  logic                    s_i_rready,
   input  logic [AXI_ID_WIDTH-1:0] s_d_arid,
   input  logic [PADDR_WIDTH-1:0]  s_d_araddr,
   input  logic [7:0]              s_d_arlen,
   input  logic [2:0]              s_d_arsize,
   input  logic [1:0]              s_d_arburst,
   input  logic                    s_d_arvalid,
   output logic                    s_d_arready,
   output logic [AXI_ID_WIDTH-1:0] s_d_rid,
   output logic [511:0]            s_d_rdata,
   output logic [1:0]              s_d_rresp,
   output logic                    s_d_rlast,
   output logic                    s_d_rvalid,
   input  logic                    s_d_rready,
   input  logic [AXI_ID_WIDTH-1:0] s_d_awid,
   input  logic [PADDR_WIDTH-1:0]  s_d_awaddr,
   input  logic [7:0]              s_d_awlen,
   input  logic [2:0]              s_d_awsize,
   input  logic [1:0]              s_d_awburst,
   input  logic                    s_d_awvalid,
   output logic                    s_d_awready,
   input  logic [511:0]            s_d_wdata,
   input  logic [63:0]             s_d_wstrb,
   input  logic                    s_d_wlast,
   input  logic                    s_d_wvalid,
   output logic                    s_d_wready,
   output logic [AXI_ID_WIDTH-1:0] s_d_bid,
   output logic [1:0]              s_d_bresp,
   output logic                    s_d_bvalid,
   input  logic                    s_d_bready,
   output logic [AXI_ID_WIDTH:0]   m_axi_arid,
   output logic [PADDR_WIDTH-1:0]  m_axi_araddr,
   output logic [7:0]              m_axi_arlen,
   output logic [2:0]              m_axi_arsize,
   output logic [1:0]              m_axi_arburst,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [AXI_ID_WIDTH:0]   m_axi_rid,
   input  logic [511:0]            m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rlast,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready,
   output logic [AXI_ID_WIDTH:0]   m_axi_awid,
   output logic [PADDR_WIDTH-1:0]  m_axi_awaddr,
   output logic [7:0]              m_axi_awlen,
   output logic [2:0]              m_axi_awsize,
   output logic [1:0]              m_axi_awburst,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [511:0]            m_axi_wdata,
   output logic [63:0]             m_axi_wstrb,
   output logic                    m_axi_wlast,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [AXI_ID_WIDTH:0]   m_axi_bid,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

   logic [AXI_ID_WIDTH:0]  arid_q, arid_d;
   logic [PADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [7:0]             arlen_q, arlen_d;
   logic [2:0]             arsize_q, arsize_d;
   logic [1:0]             arburst_q, arburst_d;
   logic                   arvalid_q, arvalid_d;
   logic [CW-1:0]          cnt_i_q, cnt_i_d;
   logic [CW-1:0]          cnt_d_q, cnt_d_d;

   logic slot_free, elig_i, elig_d, pick_d, grant_i, grant_d;
   logic r_sel_d, r_done_i, r_done_d;

   assign slot_free = !arvalid_q || m_axi_arready;
   assign elig_i    = s_i_arvalid && (cnt_i_q < MAX_CNT);
   assign elig_d    = s_d_arvalid && (cnt_d_q < MAX_CNT);

`ifdef NEBULA_AXI_MERGE_FIXED_PRIO_EN
   assign pick_d = elig_d;
`else
   logic last_d_q, last_d_d;

   // D takes a tie only when I was the most recent grant.
   assign pick_d = elig_d && (!elig_i || !last_d_q);

   always_comb begin
      last_d_d = last_d_q;
      if (grant_i) last_d_d = 1'b0;
      if (grant_d) last_d_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_d_q <= 1'b1;
      else        last_d_q <= last_d_d;
   end
`endif

   // rst_n gates the grants so nothing is accepted while the domain is held in reset.
   assign grant_d = rst_n && slot_free && pick_d;
   assign grant_i = rst_n && slot_free && elig_i && !pick_d;
   assign s_i_arready = grant_i;
   assign s_d_arready = grant_d;

   assign r_sel_d  = m_axi_rid[AXI_ID_WIDTH];
   assign r_done_i = m_axi_rvalid && m_axi_rready && m_axi_rlast && !r_sel_d;
   assign r_done_d = m_axi_rvalid && m_axi_rready && m_axi_rlast &&  r_sel_d;

   always_comb begin
      arid_d    = arid_q;
      araddr_d  = araddr_q;
      arlen_d   = arlen_q;
      arsize_d  = arsize_q;
      arburst_d = arburst_q;
      arvalid_d = arvalid_q;
      if (arvalid_q && m_axi_arready) arvalid_d = 1'b0;
      if (grant_i) begin
         arid_d    = {1'b0, s_i_arid};
         araddr_d  = s_i_araddr;
         arlen_d   = s_i_arlen;
         arsize_d  = s_i_arsize;
         arburst_d = s_i_arburst;
         arvalid_d = 1'b1;
      end else if (grant_d) begin
         arid_d    = {1'b1, s_d_arid};
         araddr_d  = s_d_araddr;
         arlen_d   = s_d_arlen;
         arsize_d  = s_d_arsize;
         arburst_d = s_d_arburst;
         arvalid_d = 1'b1;
      end
   end

   always_comb begin
      cnt_i_d = cnt_i_q;
      case ({grant_i, r_done_i})
         2'b10:   cnt_i_d = cnt_i_q + CW'(1);
         2'b01:   if (cnt_i_q != '0) cnt_i_d = cnt_i_q - CW'(1);
         default: cnt_i_d = cnt_i_q;
      endcase
      cnt_d_d = cnt_d_q;
      case ({grant_d, r_done_d})
         2'b10:   cnt_d_d = cnt_d_q + CW'(1);
         2'b01:   if (cnt_d_q != '0) cnt_d_d = cnt_d_q - CW'(1);
         default: cnt_d_d = cnt_d_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arid_q    <= '0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         arsize_q  <= '0;
         arburst_q <= '0;
         arvalid_q <= 1'b0;
         cnt_i_q   <= '0;
         cnt_d_q   <= '0;
      end else begin
         arid_q    <= arid_d;
         araddr_q  <= araddr_d;
         arlen_q   <= arlen_d;
         arsize_q  <= arsize_d;
         arburst_q <= arburst_d;
         arvalid_q <= arvalid_d;
         cnt_i_q   <= cnt_i_d;
         cnt_d_q   <= cnt_d_d;
      end
   end

   assign m_axi_arid    = arid_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arlen   = arlen_q;
   assign m_axi_arsize  = arsize_q;
   assign m_axi_arburst = arburst_q;
   assign m_axi_arvalid = arvalid_q;

   assign s_i_rdata    = m_axi_rdata;
   assign s_i_rresp    = m_axi_rresp;
   assign s_i_rlast    = m_axi_rlast;
   assign s_i_rvalid   = m_axi_rvalid && !r_sel_d;
   assign s_d_rid      = m_axi_rid[AXI_ID_WIDTH-1:0];
   assign s_d_rdata    = m_axi_rdata;
   assign s_d_rresp    = m_axi_rresp;
   assign s_d_rlast    = m_axi_rlast;
   assign s_d_rvalid   = m_axi_rvalid && r_sel_d;
   assign m_axi_rready = r_sel_d ? s_d_rready : s_i_rready;

   assign m_axi_awid    = {1'b1, s_d_awid};
   assign m_axi_awaddr  = s_d_awaddr;
   assign m_axi_awlen   = s_d_awlen;
   assign m_axi_awsize  = s_d_awsize;
   assign m_axi_awburst = s_d_awburst;
   assign m_axi_awvalid = s_d_awvalid;
   assign s_d_awready   = m_axi_awready;
   assign m_axi_wdata   = s_d_wdata;
   assign m_axi_wstrb   = s_d_wstrb;
   assign m_axi_wlast   = s_d_wlast;
   assign m_axi_wvalid  = s_d_wvalid;
   assign s_d_wready    = m_axi_wready;
   assign s_d_bid       = m_axi_bid[AXI_ID_WIDTH-1:0];
   assign s_d_bresp     = m_axi_bresp;
   assign s_d_bvalid    = m_axi_bvalid;
   assign m_axi_bready  = s_d_bready;

endmodule

// File: tb/tb_nebula_axi_merge.sv
// Scoreboard bench for nebula_axi_merge: expected master ARs are queued at upstream grant
// and popped by a monitor on each master AR handshake.
module tb_nebula_axi_merge;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [3:0]   s_i_arid, s_d_arid, s_d_rid, s_d_awid, s_d_bid;
   logic [55:0]  s_i_araddr, s_d_araddr, s_d_awaddr, m_axi_araddr, m_axi_awaddr;
   logic [7:0]   s_i_arlen, s_d_arlen, s_d_awlen, m_axi_arlen, m_axi_awlen;
   logic [2:0]   s_i_arsize, s_d_arsize, s_d_awsize, m_axi_arsize, m_axi_awsize;
   logic [1:0]   s_i_arburst, s_d_arburst, s_d_awburst, m_axi_arburst, m_axi_awburst;
   logic         s_i_arvalid, s_i_arready, s_d_arvalid, s_d_arready;
   logic [511:0] s_i_rdata, s_d_rdata, s_d_wdata, m_axi_rdata, m_axi_wdata;
   logic [1:0]   s_i_rresp, s_d_rresp, s_d_bresp, m_axi_rresp, m_axi_bresp;
   logic         s_i_rlast, s_i_rvalid, s_i_rready, s_d_rlast, s_d_rvalid, s_d_rready;
   logic         s_d_awvalid, s_d_awready, s_d_wlast, s_d_wvalid, s_d_wready;
   logic [63:0]  s_d_wstrb, m_axi_wstrb;
   logic         s_d_bvalid, s_d_bready;
   logic [4:0]   m_axi_arid, m_axi_rid, m_axi_awid, m_axi_bid;
   logic         m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
   logic         m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
   logic         m_axi_bvalid, m_axi_bready;

   nebula_axi_merge dut (
      .clk(clk), .rst_n(rst_n),
      .s_i_arid(s_i_arid), .s_i_araddr(s_i_araddr), .s_i_arlen(s_i_arlen), .s_i_arsize(s_i_arsize),
      .s_i_arburst(s_i_arburst), .s_i_arvalid(s_i_arvalid), .s_i_arready(s_i_arready),
      .s_i_rdata(s_i_rdata), .s_i_rresp(s_i_rresp), .s_i_rlast(s_i_rlast), .s_i_rvalid(s_i_rvalid),
      .s_i_rready(s_i_rready),
      .s_d_arid(s_d_arid), .s_d_araddr(s_d_araddr), .s_d_arlen(s_d_arlen), .s_d_arsize(s_d_arsize),
      .s_d_arburst(s_d_arburst), .s_d_arvalid(s_d_arvalid), .s_d_arready(s_d_arready),
      .s_d_rid(s_d_rid), .s_d_rdata(s_d_rdata), .s_d_rresp(s_d_rresp), .s_d_rlast(s_d_rlast),
      .s_d_rvalid(s_d_rvalid), .s_d_rready(s_d_rready),
      .s_d_awid(s_d_awid), .s_d_awaddr(s_d_awaddr), .s_d_awlen(s_d_awlen), .s_d_awsize(s_d_awsize),
      .s_d_awburst(s_d_awburst), .s_d_awvalid(s_d_awvalid), .s_d_awready(s_d_awready),
      .s_d_wdata(s_d_wdata), .s_d_wstrb(s_d_wstrb), .s_d_wlast(s_d_wlast), .s_d_wvalid(s_d_wvalid),
      .s_d_wready(s_d_wready), .s_d_bid(s_d_bid), .s_d_bresp(s_d_bresp), .s_d_bvalid(s_d_bvalid),
      .s_d_bready(s_d_bready),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
      .m_axi_arready(m_axi_arready),
      .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
      .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(m_axi_bready)
   );

   int checks = 0;
   int errors = 0;
   logic [68:0] exp_q[$];   // {arid[4:0], araddr[55:0], arlen[7:0]}

   always @(negedge clk) begin
      if (rst_n === 1'b1 && m_axi_arvalid === 1'b1 && m_axi_arready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL ar_unexpected: got id=%h addr=%h, none expected", m_axi_arid, m_axi_araddr);
         end else begin
            logic [68:0] e;
            e = exp_q.pop_front();
            if ({m_axi_arid, m_axi_araddr, m_axi_arlen} !== e) begin
               errors++;
               $display("FAIL ar_order: got id=%h addr=%h len=%h, expected id=%h addr=%h len=%h",
                        m_axi_arid, m_axi_araddr, m_axi_arlen, e[68:64], e[63:8], e[7:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      s_i_arvalid = 0; s_d_arvalid = 0; s_i_arid = 0; s_d_arid = 0;
      s_i_araddr = 0; s_d_araddr = 0; s_i_arlen = 0; s_d_arlen = 0;
      s_i_arsize = 3'd6; s_d_arsize = 3'd6; s_i_arburst = 2'd1; s_d_arburst = 2'd1;
      s_i_rready = 1; s_d_rready = 1;
      s_d_awid = 0; s_d_awaddr = 0; s_d_awlen = 0; s_d_awsize = 0; s_d_awburst = 0; s_d_awvalid = 0;
      s_d_wdata = 0; s_d_wstrb = 0; s_d_wlast = 0; s_d_wvalid = 0; s_d_bready = 0;
      m_axi_arready = 1; m_axi_rid = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0;
      m_axi_rvalid = 0; m_axi_awready = 0; m_axi_wready = 0; m_axi_bid = 0; m_axi_bresp = 0;
      m_axi_bvalid = 0;
   endtask

   task automatic apply_reset();
      rst_n = 0;
      clear_inputs();
      exp_q.delete();
      tick(); tick();
      rst_n = 1;
      tick();
   endtask

   // Drives one AR on one source for a single cycle and records the master AR it should produce.
   task automatic issue(input bit src, input logic [3:0] id, input logic [55:0] addr, input logic [7:0] len);
      if (src) begin s_d_arvalid = 1; s_d_arid = id; s_d_araddr = addr; s_d_arlen = len; end
      else     begin s_i_arvalid = 1; s_i_arid = id; s_i_araddr = addr; s_i_arlen = len; end
      exp_q.push_back({src, id, addr, len});
      tick();
      s_i_arvalid = 0; s_d_arvalid = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      clear_inputs();
      s_i_arvalid = 1; s_d_arvalid = 1;
      m_axi_rvalid = 1; m_axi_rid = 5'h10;
      tick();
      @(negedge clk);
      checks++;
      if ({m_axi_arvalid, s_i_arready, s_d_arready} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ready: got arvalid/i_rdy/d_rdy=%b, expected 000", {m_axi_arvalid, s_i_arready, s_d_arready});
      end
      checks++;
      if ({m_axi_arid, m_axi_araddr, dut.cnt_i_q, dut.cnt_d_q} !== '0) begin
         errors++;
         $display("FAIL reset_state: got arid=%h araddr=%h cnt_i=%0d cnt_d=%0d, expected all 0",
                  m_axi_arid, m_axi_araddr, dut.cnt_i_q, dut.cnt_d_q);
      end
      checks++;
      if ({s_d_rvalid, s_i_rvalid} !== 2'b10) begin
         errors++;
         $display("FAIL reset_comb_r: got d/i rvalid=%b, expected 10", {s_d_rvalid, s_i_rvalid});
      end
      apply_reset();
   endtask

   task automatic test_single_i_read();
      apply_reset();
      s_i_arvalid = 1; s_i_arid = 4'h3; s_i_araddr = 56'h1000; s_i_arlen = 0;
      @(negedge clk);
      checks++;
      if ({s_i_arready, s_d_arready} !== 2'b10) begin
         errors++;
         $display("FAIL single_grant: got i/d arready=%b, expected 10", {s_i_arready, s_d_arready});
      end
      exp_q.push_back({5'h03, 56'h1000, 8'h00});
      tick();
      s_i_arvalid = 0;
      @(negedge clk);
      checks++;
      if ({m_axi_arvalid, m_axi_arid, m_axi_araddr} !== {1'b1, 5'h03, 56'h1000}) begin
         errors++;
         $display("FAIL single_latency: got arvalid=%b id=%h addr=%h, expected 1 03 1000",
                  m_axi_arvalid, m_axi_arid, m_axi_araddr);
      end
      tick();
      s_d_rready = 0;
      m_axi_rvalid = 1; m_axi_rid = 5'h03; m_axi_rdata = {64{8'hA5}}; m_axi_rresp = 0; m_axi_rlast = 1;
      @(negedge clk);
      checks++;
      if ({s_i_rvalid, s_d_rvalid, s_i_rlast, m_axi_rready} !== 4'b1011 || s_i_rdata !== {64{8'hA5}}) begin
         errors++;
         $display("FAIL single_r_route: got i_rv/d_rv/i_last/m_rready=%b data[31:0]=%h, expected 1011 a5a5a5a5",
                  {s_i_rvalid, s_d_rvalid, s_i_rlast, m_axi_rready}, s_i_rdata[31:0]);
      end
      tick();
      m_axi_rvalid = 0;
      @(negedge clk);
      checks++;
      if (dut.cnt_i_q !== 0) begin
         errors++;
         $display("FAIL single_cnt_release: got cnt_i=%0d, expected 0", dut.cnt_i_q);
      end
   endtask

   task automatic test_arbitration();
`ifdef NEBULA_AXI_MERGE_FIXED_PRIO_EN
      bit order[5] = '{1, 1, 1, 1, 0};
`else
      bit order[4] = '{0, 1, 0, 1};
`endif
      logic [55:0] a_i, a_d;
      apply_reset();
      a_i = 56'h100; a_d = 56'h200;
      s_i_arvalid = 1; s_i_arid = 4'h1; s_i_araddr = a_i;
      s_d_arvalid = 1; s_d_arid = 4'h2; s_d_araddr = a_d;
      foreach (order[k]) begin
         @(negedge clk);
         checks++;
         if ({s_i_arready, s_d_arready} !== {!order[k], order[k]}) begin
            errors++;
            $display("FAIL arb_order[%0d]: got i/d arready=%b, expected %b", k,
                     {s_i_arready, s_d_arready}, {!order[k], order[k]});
         end
         if (order[k]) exp_q.push_back({5'h12, a_d, 8'h00});
         else          exp_q.push_back({5'h01, a_i, 8'h00});
         tick();
         if (order[k]) begin a_d = a_d + 56'h40; s_d_araddr = a_d; end
         else          begin a_i = a_i + 56'h40; s_i_araddr = a_i; end
      end
      s_i_arvalid = 0; s_d_arvalid = 0;
      tick();
   endtask

   task automatic test_outstanding_limit();
      apply_reset();
      for (int k = 0; k < 4; k++) issue(1'b1, 4'h0, 56'h8000 + 56'(k) * 56'h40, 8'h00);
      s_d_arvalid = 1; s_d_arid = 4'h0; s_d_araddr = 56'h8100;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (s_d_arready !== 1'b0) begin
            errors++;
            $display("FAIL limit_stall[%0d]: got s_d_arready=%b, expected 0", k, s_d_arready);
         end
         tick();
      end
      m_axi_rvalid = 1; m_axi_rid = 5'h10; m_axi_rlast = 1;
      @(negedge clk);
      checks++;
      if ({s_d_rvalid, s_d_arready} !== 2'b10) begin
         errors++;
         $display("FAIL limit_no_bypass: got d_rvalid/d_arready=%b, expected 10", {s_d_rvalid, s_d_arready});
      end
      tick();
      m_axi_rvalid = 0;
      @(negedge clk);
      checks++;
      if (s_d_arready !== 1'b1) begin
         errors++;
         $display("FAIL limit_release: got s_d_arready=%b, expected 1", s_d_arready);
      end
      exp_q.push_back({5'h10, 56'h8100, 8'h00});
      tick();
      s_d_arvalid = 0;
      tick();
   endtask

   task automatic test_backpressure();
      apply_reset();
      m_axi_arready = 0;
      issue(1'b0, 4'h1, 56'h3000, 8'h03);
      s_i_arvalid = 1; s_i_arid = 4'h2; s_i_araddr = 56'h3040; s_i_arlen = 8'h00;
      s_d_arvalid = 1; s_d_arid = 4'h4; s_d_araddr = 56'h4000; s_d_arlen = 8'h07;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if ({m_axi_arvalid, m_axi_arid, m_axi_araddr, m_axi_arlen, s_i_arready, s_d_arready} !==
             {1'b1, 5'h01, 56'h3000, 8'h03, 2'b00}) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got arvalid=%b id=%h addr=%h len=%h i/d rdy=%b, expected 1 01 3000 03 00",
                     k, m_axi_arvalid, m_axi_arid, m_axi_araddr, m_axi_arlen, {s_i_arready, s_d_arready});
         end
         tick();
      end
      m_axi_arready = 1;
      @(negedge clk);
      checks++;
      if ({s_i_arready, s_d_arready} !== 2'b01) begin
         errors++;
         $display("FAIL bp_release_grant: got i/d arready=%b, expected 01", {s_i_arready, s_d_arready});
      end
      exp_q.push_back({5'h14, 56'h4000, 8'h07});
      tick();
      s_d_arvalid = 0;
      @(negedge clk);
      checks++;
      if ({s_i_arready, s_d_arready} !== 2'b10) begin
         errors++;
         $display("FAIL bp_next_grant: got i/d arready=%b, expected 10", {s_i_arready, s_d_arready});
      end
      exp_q.push_back({5'h02, 56'h3040, 8'h00});
      tick();
      s_i_arvalid = 0;
      tick();
   endtask

   task automatic test_write();
      apply_reset();
      s_d_awvalid = 1; s_d_awid = 4'h2; s_d_awaddr = 56'h2000; s_d_awlen = 8'h01; s_d_awsize = 3'd6;
      s_d_awburst = 2'd1; m_axi_awready = 1;
      s_d_wvalid = 1; s_d_wdata = {16{32'hDEADBEEF}}; s_d_wstrb = '1; s_d_wlast = 1; m_axi_wready = 1;
      @(negedge clk);
      checks++;
      if ({m_axi_awvalid, m_axi_awid, m_axi_awaddr, m_axi_awlen, s_d_awready} !== {1'b1, 5'h12, 56'h2000, 8'h01, 1'b1}) begin
         errors++;
         $display("FAIL wr_aw: got awvalid=%b id=%h addr=%h len=%h awready=%b, expected 1 12 2000 01 1",
                  m_axi_awvalid, m_axi_awid, m_axi_awaddr, m_axi_awlen, s_d_awready);
      end
      checks++;
      if ({m_axi_wvalid, m_axi_wlast, s_d_wready} !== 3'b111 || m_axi_wstrb !== '1 ||
          m_axi_wdata !== {16{32'hDEADBEEF}}) begin
         errors++;
         $display("FAIL wr_w: got wvalid/wlast/wready=%b strb=%h data[31:0]=%h, expected 111 all-ones deadbeef",
                  {m_axi_wvalid, m_axi_wlast, s_d_wready}, m_axi_wstrb, m_axi_wdata[31:0]);
      end
      tick();
      s_d_awvalid = 0; s_d_wvalid = 0;
      m_axi_bvalid = 1; m_axi_bid = 5'h12; m_axi_bresp = 2'd0; s_d_bready = 1;
      @(negedge clk);
      checks++;
      if ({s_d_bvalid, s_d_bid, s_d_bresp, m_axi_bready} !== {1'b1, 4'h2, 2'd0, 1'b1}) begin
         errors++;
         $display("FAIL wr_b: got bvalid=%b bid=%h bresp=%h bready=%b, expected 1 2 0 1",
                  s_d_bvalid, s_d_bid, s_d_bresp, m_axi_bready);
      end
      tick();
      m_axi_bvalid = 0;
      @(negedge clk);
      checks++;
      if ({dut.cnt_i_q, dut.cnt_d_q, m_axi_arvalid} !== '0) begin
         errors++;
         $display("FAIL wr_no_read_effect: got cnt_i=%0d cnt_d=%0d arvalid=%b, expected 0 0 0",
                  dut.cnt_i_q, dut.cnt_d_q, m_axi_arvalid);
      end
   endtask

   task automatic test_reset_mid_op();
      apply_reset();
      issue(1'b0, 4'h5, 56'hA000, 8'h00);
      issue(1'b0, 4'h5, 56'hA040, 8'h00);
      issue(1'b1, 4'h6, 56'hB000, 8'h00);
      s_d_arvalid = 1; s_d_arid = 4'h6; s_d_araddr = 56'hB040; s_d_arlen = 0;
      tick();
      s_d_arvalid = 0;
      m_axi_arready = 0;
      @(negedge clk);
      checks++;
      if ({m_axi_arvalid, m_axi_araddr, 4'(dut.cnt_i_q), 4'(dut.cnt_d_q)} !== {1'b1, 56'hB040, 4'd2, 4'd2}) begin
         errors++;
         $display("FAIL midrst_setup: got arvalid=%b addr=%h cnt_i=%0d cnt_d=%0d, expected 1 b040 2 2",
                  m_axi_arvalid, m_axi_araddr, dut.cnt_i_q, dut.cnt_d_q);
      end
      #1 rst_n = 0;
      #1;
      checks++;
      if ({m_axi_arvalid, dut.cnt_i_q, dut.cnt_d_q} !== '0) begin
         errors++;
         $display("FAIL midrst_clear: got arvalid=%b cnt_i=%0d cnt_d=%0d, expected 0 0 0",
                  m_axi_arvalid, dut.cnt_i_q, dut.cnt_d_q);
      end
      exp_q.delete();
      tick();
      rst_n = 1;
      tick();
      m_axi_arready = 1;
      s_i_arvalid = 1; s_i_arid = 4'h7; s_i_araddr = 56'hC000;
      s_d_arvalid = 1; s_d_arid = 4'h8; s_d_araddr = 56'hD000;
      @(negedge clk);
      checks++;
`ifdef NEBULA_AXI_MERGE_FIXED_PRIO_EN
      if ({s_i_arready, s_d_arready} !== 2'b01) begin
         errors++;
         $display("FAIL midrst_first_tie: got i/d arready=%b, expected 01", {s_i_arready, s_d_arready});
      end
      exp_q.push_back({5'h18, 56'hD000, 8'h00});
`else
      if ({s_i_arready, s_d_arready} !== 2'b10) begin
         errors++;
         $display("FAIL midrst_first_tie: got i/d arready=%b, expected 10", {s_i_arready, s_d_arready});
      end
      exp_q.push_back({5'h07, 56'hC000, 8'h00});
`endif
      tick();
      s_i_arvalid = 0; s_d_arvalid = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_i_read();
      test_arbitration();
      test_outstanding_limit();
      test_backpressure();
      test_write();
      test_reset_mid_op();
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d ARs never seen on master, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
